// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM pattern test harness: FSM state codes,
// pattern identifiers and the number of patterns cycled through per loop.
package ram_test_pkg;

  typedef enum logic [7:0] {
    START    = 8'd1,
    WRITE    = 8'd2,
    VERIFY   = 8'd3,
    NEXT_PAT = 8'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_INV   = 2'd1,
    PAT_CHECK = 2'd2
  } pattern_t;

  localparam int NUM_PATTERNS = 3;

endpackage

// File: rtl/ram_test_pattern_gen.sv
// Combinational test-pattern generator. Produces the data word for a given
// pattern id and address: the address itself, its inverse, or a checkerboard
// whose phase flips with the address LSB so neighbouring words differ.
module ram_test_pattern_gen
  import ram_test_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 1
) (
  input  logic [1:0]            sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  // The address is zero-extended first and then cut to the word width, so
  // either width relation works without special cases.
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] addr_ext;
  logic [DATA_WIDTH-1:0]            addr_word;
  logic [DATA_WIDTH-1:0]            cb_word;
  logic                             unused_addr_bits;

  assign addr_ext         = {{DATA_WIDTH{1'b0}}, addr};
  assign addr_word        = addr_ext[DATA_WIDTH-1:0];
  assign unused_addr_bits = ^addr_ext;

  // Select the pattern word; checkerboard is ..1010 xor'd with the address LSB
  always_comb begin
    cb_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cb_word[i] = (i % 2 == 1) ^ addr[0];
    end
    case (sel)
      PAT_INV:   data = ~addr_word;
      PAT_CHECK: data = cb_word;
      default:   data = addr_word;
    endcase
  end

endmodule

// File: rtl/ram_pattern_writer.sv
// Memory test sequencer: fills the RAM under test with a pattern, reads each
// word back after the RAM's read latency, compares it with the regenerated
// pattern and records miscompares. Cycles through all patterns forever.
module ram_pattern_writer
  import ram_test_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 1,
  parameter int ADDRESS_STEP = 1,
  parameter int MAX_ADDRESS  = 63,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  loop_complete,
  output logic                  error,
  output logic [15:0]           error_count,
  output logic [7:0]            error_state,
  output logic [ADDR_WIDTH-1:0] error_address,
  output logic [DATA_WIDTH-1:0] expected_data,
  output logic [DATA_WIDTH-1:0] actual_data
);

  // One extra address bit so stepping past the top of the address space is
  // seen as "last address" instead of silently wrapping to zero.
  localparam logic [ADDR_WIDTH:0] STEP_EXT = (ADDR_WIDTH+1)'(ADDRESS_STEP);
  localparam logic [ADDR_WIDTH:0] MAX_EXT  = (ADDR_WIDTH+1)'(MAX_ADDRESS);
  localparam logic [1:0]          LAT      = 2'(READ_LATENCY);
  localparam logic [1:0]          LAST_PAT = 2'(NUM_PATTERNS - 1);

  state_t                state, state_next;
  logic [1:0]            pattern_sel;
  logic [1:0]            delay;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   next_addr;
  logic                  is_last;
  logic                  compare_due;
  logic                  miscompare;
  logic [DATA_WIDTH-1:0] pat_write;
  logic [DATA_WIDTH-1:0] pat_compare;

  assign next_addr   = {1'b0, addr} + STEP_EXT;
  assign is_last     = next_addr > MAX_EXT;
  assign compare_due = (state == VERIFY) && (delay == LAT);
  assign miscompare  = compare_due && (read_data != pat_compare);

  ram_test_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pat_write (
    .sel (pattern_sel),
    .addr(addr),
    .data(pat_write)
  );

  ram_test_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pat_compare (
    .sel (pattern_sel),
    .addr(addr),
    .data(pat_compare)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= START;
    else     state <= state_next;
  end

  // Next-state logic and memory strobes; write and read ports are idle outside their phase
  always_comb begin
    state_next    = state;
    write_enable  = 1'b0;
    write_address = '0;
    write_data    = '0;
    read_address  = '0;
    case (state)
      START: state_next = WRITE;
      WRITE: begin
        write_enable  = 1'b1;
        write_address = addr;
        write_data    = pat_write;
        if (is_last) state_next = VERIFY;
      end
      VERIFY: begin
        read_address = addr;
        if (compare_due && is_last) state_next = NEXT_PAT;
      end
      NEXT_PAT: state_next = START;
      default:  state_next = START;
    endcase
  end

  // Address sweep, read-latency delay counter, pattern selection and loop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      delay         <= '0;
      pattern_sel   <= '0;
      loop_complete <= 1'b0;
    end else begin
      case (state)
        START: begin
          addr          <= '0;
          delay         <= '0;
          loop_complete <= 1'b0;
        end
        WRITE: begin
          if (is_last) addr <= '0;
          else         addr <= next_addr[ADDR_WIDTH-1:0];
        end
        VERIFY: begin
          if (compare_due) begin
            delay <= '0;
            if (is_last) addr <= '0;
            else         addr <= next_addr[ADDR_WIDTH-1:0];
          end else begin
            delay <= delay + 2'd1;
          end
        end
        NEXT_PAT: begin
          if (pattern_sel < LAST_PAT) begin
            pattern_sel <= pattern_sel + 2'd1;
          end else begin
            pattern_sel   <= '0;
            loop_complete <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Miscompare capture: error pulses one cycle, details hold until the next miscompare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error         <= 1'b0;
      error_count   <= '0;
      error_state   <= '0;
      error_address <= '0;
      expected_data <= '0;
      actual_data   <= '0;
    end else begin
      error <= 1'b0;
      if (miscompare) begin
        error         <= 1'b1;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        error_state   <= VERIFY;
        error_address <= addr;
        expected_data <= pat_compare;
        actual_data   <= read_data;
      end
    end
  end

endmodule
